ecc_encode_buffer: RTL



---
 rtl/ecc_pkg.sv | 25 ++
 rtl/ecc_reg_fifo.sv | 58 +++++
 rtl/ecc_encode_buffer.sv | 76 +++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions for the encode buffer and the downstream decoder.
// Both sides call ecc_check so the two cannot disagree on the check byte.
package ecc_pkg;

  localparam int unsigned ECC_DATA_W = 64;
  localparam int unsigned ECC_CODE_W = 72;
  localparam int unsigned ECC_CHK_W  = ECC_CODE_W - ECC_DATA_W;

  typedef logic [ECC_DATA_W-1:0] ecc_data_t;
  typedef logic [ECC_CHK_W-1:0]  ecc_chk_t;
  typedef logic [ECC_CODE_W-1:0] ecc_code_t;

  // Check byte: bit 0 is even parity over the data, upper bits reserved as zero.
  function automatic ecc_chk_t ecc_check(input ecc_data_t data);
    ecc_chk_t chk;
    chk    = '0;
    chk[0] = ^data;
    return chk;
  endfunction

  function automatic ecc_code_t ecc_encode(input ecc_data_t data);
    return {ecc_check(data), data};
  endfunction

endpackage

// File: rtl/ecc_reg_fifo.sv
// Generic DEPTH x W synchronous register FIFO with occupancy count.
// Push is ignored when full and pop when empty; reset clears the storage.
module ecc_reg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 72
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ecc_encode_buffer.sv
// Write-path stage: appends the ECC check byte to each 64-bit word and buffers
// codewords for the memory side, with a one-shot parity-corruption hook.
module ecc_encode_buffer
  import ecc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [71:0]            out_data,
  input  logic                   inject_err,
  output logic                   inject_pending,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       words_count
);

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      corrupt;
  ecc_code_t wr_code;

  assign in_ready  = !full && !sys_rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A pulse coinciding with a push corrupts that word directly, never arming.
  assign corrupt = inject_err || inject_pending;

  always_comb begin
    wr_code             = ecc_encode(in_data);
    wr_code[ECC_DATA_W] = wr_code[ECC_DATA_W] ^ corrupt;
  end

  ecc_reg_fifo #(
    .DEPTH (DEPTH),
    .W     (ECC_CODE_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_code),
    .rd_data (out_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      inject_pending <= 1'b0;
    end else if (push) begin
      inject_pending <= 1'b0;
    end else if (inject_err) begin
      inject_pending <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      words_count <= '0;
    end else if (pop) begin
      words_count <= words_count + 1'b1;
    end
  end

endmodule
